data_mem_lsu: RTL and testbench

//  Parametrised byte-addressed RISC-V data memory with a valid/ready request port and registered response.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/dmem_load_fmt.sv | 36 +++
 rtl/data_mem_lsu.sv | 161 ++++++++++++++++
 tb/tb_data_mem_lsu.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store definitions: funct3 encodings, LSU FSM states and
// the access-legality check.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} lsu_state_t;

  // 1 when the access is misaligned or the funct3 is not valid for its direction.
  function automatic logic lsu_access_err(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic err;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = addr_lo[0];
      F3_W:    err = (addr_lo != 2'b00);
      F3_BU:   err = we;
      F3_HU:   err = we | addr_lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_load_fmt.sv
// Load formatter: picks the addressed byte/half/word out of an aligned 32-bit
// word according to byte order, then sign- or zero-extends it.
module dmem_load_fmt
  import riscv_pkg::*;
#(
  parameter int unsigned BIG_ENDIAN = 0
) (
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_raw;
  logic [15:0] half_sel;
  logic [31:0] word_sel;

  always_comb begin
    byte_sel = 8'(word >> {addr_lo, 3'b000});
    half_raw = addr_lo[1] ? word[31:16] : word[15:0];
    // Storage is little-endian by lane, so big-endian units are lane-swapped.
    half_sel = (BIG_ENDIAN != 0) ? {half_raw[7:0], half_raw[15:8]} : half_raw;
    word_sel = (BIG_ENDIAN != 0) ? {word[7:0], word[15:8], word[23:16], word[31:24]} : word;

    case (funct3)
      F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata = {24'h0, byte_sel};
      F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata = {16'h0, half_sel};
      F3_W:    rdata = word_sel;
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressed data memory with a valid/ready request port, configurable read
// latency and a registered, one-outstanding response.
module data_mem_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned BIG_ENDIAN = 0,
  parameter string       INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned Bytes = 2 ** ADDR_W;

  logic [7:0] mem [Bytes];

  lsu_state_t        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [2:0]        hold_f3_q;

  logic              accept;
  logic              acc_err;
  logic              wr_en;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic [15:0]       wr_half;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        rd_f3;
  logic [31:0]       rd_word;
  logic [31:0]       load_data;

  assign req_ready = (state_q == IDLE) || (state_q == RESP);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign accept  = req_valid & req_ready;
  assign acc_err = lsu_access_err(req_we, req_funct3, req_addr[1:0]);
  assign wr_en   = accept & req_we & ~acc_err;

  // Store steering: replicate the unit across lanes, enable only the addressed ones.
  always_comb begin
    wr_half = (BIG_ENDIAN != 0) ? {req_wdata[7:0], req_wdata[15:8]} : req_wdata[15:0];
    wr_data = req_wdata;
    wr_be   = 4'b0000;
    case (req_funct3[1:0])
      2'b00: begin
        wr_data = {4{req_wdata[7:0]}};
        wr_be   = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        wr_data = {2{wr_half}};
        wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        wr_data = (BIG_ENDIAN != 0)
                  ? {req_wdata[7:0], req_wdata[15:8], req_wdata[23:16], req_wdata[31:24]}
                  : req_wdata;
        wr_be   = 4'b1111;
      end
      default: wr_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[{req_addr[ADDR_W-1:2], 2'(i)}] <= wr_data[8*i +: 8];
      end
    end
  end

  // Latency-1 loads read with the live request; longer ones use the held copy.
  assign rd_addr = accept ? req_addr : hold_addr_q;
  assign rd_f3   = accept ? req_funct3 : hold_f3_q;

  always_comb begin
    rd_word = 32'h0;
    for (int i = 0; i < 4; i++) begin
      rd_word[8*i +: 8] = mem[{rd_addr[ADDR_W-1:2], 2'(i)}];
    end
  end

  dmem_load_fmt #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_load_fmt (
    .word   (rd_word),
    .addr_lo(rd_addr[1:0]),
    .funct3 (rd_f3),
    .rdata  (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          rdata_d = 32'h0;
          err_d   = acc_err;
          cnt_d   = 3'd0;
          if (acc_err || req_we || (RD_LATENCY <= 1)) begin
            state_d = RESP;
            if (!acc_err && !req_we) rdata_d = load_data;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(RD_LATENCY - 1);
          end
        end else if (state_q == RESP) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = RESP;
          rdata_d = load_data;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      hold_addr_q <= '0;
      hold_f3_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        hold_addr_q <= req_addr;
        hold_f3_q   <= req_funct3;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: three instances (latency 1 LE, latency 3 LE, latency 1 BE)
// driven by directed steps, responses checked against a per-instance scoreboard.
module tb_data_mem_lsu;
  import riscv_pkg::*;

  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n      [3];
  logic          req_valid  [3];
  logic          req_ready  [3];
  logic          req_we     [3];
  logic [2:0]    req_funct3 [3];
  logic [AW-1:0] req_addr   [3];
  logic [31:0]   req_wdata  [3];
  logic          rsp_valid  [3];
  logic [31:0]   rsp_rdata  [3];
  logic          rsp_err    [3];

  data_mem_lsu #(.ADDR_W(AW), .RD_LATENCY(1), .BIG_ENDIAN(0), .INIT_FILE("")) u_le1 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  data_mem_lsu #(.ADDR_W(AW), .RD_LATENCY(3), .BIG_ENDIAN(0), .INIT_FILE("")) u_le3 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  data_mem_lsu #(.ADDR_W(AW), .RD_LATENCY(1), .BIG_ENDIAN(1), .INIT_FILE("")) u_be1 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_funct3(req_funct3[2]), .req_addr(req_addr[2]),
    .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    time         due;
    string       tag;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  int  errors = 0;
  int  checks = 0;
  time last_acc = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int i);
    if (i == 0) return sb0.size();
    if (i == 1) return sb1.size();
    return sb2.size();
  endfunction

  task automatic rsp_check(input int i, input exp_t e);
    check32({e.tag, ".rdata"}, rsp_rdata[i], e.rdata);
    check32({e.tag, ".err"}, {31'h0, rsp_err[i]}, {31'h0, e.err});
    check32({e.tag, ".time"}, 32'($time), 32'(e.due));
  endtask

  task automatic unexpected(input int i);
    checks++;
    errors++;
    $error("FAIL unexpected_rsp inst%0d: got rsp_valid=1, want 0", i);
  endtask

  always @(negedge clk) begin
    if (rsp_valid[0] === 1'b1) begin
      if (sb0.size() == 0) unexpected(0);
      else rsp_check(0, sb0.pop_front());
    end
    if (rsp_valid[1] === 1'b1) begin
      if (sb1.size() == 0) unexpected(1);
      else rsp_check(1, sb1.pop_front());
    end
    if (rsp_valid[2] === 1'b1) begin
      if (sb2.size() == 0) unexpected(2);
      else rsp_check(2, sb2.pop_front());
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input int i, input bit we, input logic [2:0] f3,
                       input logic [AW-1:0] addr, input logic [31:0] wdata,
                       input bit expect_rsp, input logic [31:0] exp_rdata,
                       input bit exp_err, input int lat, input string tag);
    exp_t e;
    int   k;
    req_valid[i]  = 1'b1;
    req_we[i]     = we;
    req_funct3[i] = f3;
    req_addr[i]   = addr;
    req_wdata[i]  = wdata;
    k = 0;
    while (!req_ready[i] && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!req_ready[i]) begin
      checks++;
      errors++;
      $error("FAIL %s.accept: got req_ready=0 for 20 cycles, want 1", tag);
      return;
    end
    @(posedge clk);
    last_acc = $time;
    #1;
    if (expect_rsp) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.due   = last_acc + time'((lat - 1) * 10 + 5);
      e.tag   = tag;
      if (i == 0) sb0.push_back(e);
      else if (i == 1) sb1.push_back(e);
      else sb2.push_back(e);
    end
  endtask

  task automatic st(input int i, input logic [2:0] f3, input logic [AW-1:0] addr,
                    input logic [31:0] wdata, input string tag);
    issue(i, 1'b1, f3, addr, wdata, 1'b1, 32'h0, 1'b0, 1, tag);
  endtask

  task automatic ld(input int i, input logic [2:0] f3, input logic [AW-1:0] addr,
                    input logic [31:0] exp, input int lat, input string tag);
    issue(i, 1'b0, f3, addr, 32'h0, 1'b1, exp, 1'b0, lat, tag);
  endtask

  task automatic bad(input int i, input bit we, input logic [2:0] f3,
                     input logic [AW-1:0] addr, input string tag);
    issue(i, we, f3, addr, 32'hDEADBEEF, 1'b1, 32'h0, 1'b1, 1, tag);
  endtask

  task automatic idle(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic drain(input int i, input string tag);
    int k;
    k = 0;
    while (qsize(i) != 0 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check32({tag, ".pending"}, 32'(qsize(i)), 32'h0);
  endtask

  logic [31:0] vals[4];
  time         prev_acc;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i]      = 1'b0;
      req_valid[i]  = 1'b0;
      req_we[i]     = 1'b0;
      req_funct3[i] = 3'b000;
      req_addr[i]   = '0;
      req_wdata[i]  = 32'h0;
    end
    #12;
    check32("reset.req_ready", {31'h0, req_ready[0]}, 32'h1);
    check32("reset.rsp_valid", {31'h0, rsp_valid[0]}, 32'h0);
    check32("reset.rsp_rdata", rsp_rdata[0], 32'h0);
    check32("reset.rsp_err", {31'h0, rsp_err[0]}, 32'h0);
    check32("reset.req_ready_l3", {31'h0, req_ready[1]}, 32'h1);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(posedge clk);
    #1;

    // Store/load round trip, byte merge, extension, and back-to-back RAW.
    st(0, F3_W, 'h10, 32'h800000FF, "t1_sw");
    ld(0, F3_W, 'h10, 32'h800000FF, 1, "t1_lw");
    st(0, F3_B, 'h13, 32'h000000A5, "t2_sb");
    ld(0, F3_B, 'h13, 32'hFFFFFFA5, 1, "t2_lb");
    ld(0, F3_BU, 'h13, 32'h000000A5, 1, "t2_lbu");
    ld(0, F3_W, 'h10, 32'hA50000FF, 1, "t2_lw");
    ld(0, F3_H, 'h12, 32'hFFFFA500, 1, "t2_lh");
    ld(0, F3_HU, 'h12, 32'h0000A500, 1, "t2_lhu");
    idle(0);
    drain(0, "t2");

    // Misaligned and illegal accesses: error response, no array write.
    bad(0, 1'b0, F3_H, 'h11, "t3_lh_mis");
    bad(0, 1'b1, F3_W, 'h12, "t3_sw_mis");
    ld(0, F3_W, 'h10, 32'hA50000FF, 1, "t3_lw_unchanged");
    bad(0, 1'b0, 3'b011, 'h10, "t3_ld_f3_011");
    bad(0, 1'b1, F3_BU, 'h10, "t3_st_f3_100");
    bad(0, 1'b1, F3_H, 'h13, "t3_sh_mis");
    bad(0, 1'b0, F3_W, 'h11, "t3_lw_mis");
    ld(0, F3_W, 'h10, 32'hA50000FF, 1, "t3_lw_unchanged2");
    st(0, F3_W, 'h14, 32'h00000000, "t3_sw_clr");
    st(0, F3_H, 'h16, 32'h1234BEEF, "t3_sh");
    ld(0, F3_W, 'h14, 32'hBEEF0000, 1, "t3_lw_sh");
    ld(0, F3_H, 'h16, 32'hFFFFBEEF, 1, "t3_lh_sh");
    idle(0);
    drain(0, "t3");

    // Latency 3 with req_valid held across four loads.
    vals[0] = 32'h11111111;
    vals[1] = 32'h22222222;
    vals[2] = 32'h33333333;
    vals[3] = 32'h44444444;
    for (int j = 0; j < 4; j++) st(1, F3_W, AW'(32'h20 + 4 * j), vals[j], "t4_sw");
    idle(1);
    drain(1, "t4_st");
    for (int j = 0; j < 4; j++) begin
      prev_acc = last_acc;
      ld(1, F3_W, AW'(32'h20 + 4 * j), vals[j], 3, "t4_lw");
      if (j > 0) check32("t4_accept_spacing", 32'(last_acc - prev_acc), 32'd30);
      check32("t4_ready_lo1", {31'h0, req_ready[1]}, 32'h0);
      @(posedge clk);
      #1;
      check32("t4_ready_lo2", {31'h0, req_ready[1]}, 32'h0);
    end
    idle(1);
    drain(1, "t4");

    // Reset while a load is waiting: response dropped, memory retained.
    st(1, F3_W, 'h30, 32'hCAFEF00D, "t5_sw");
    issue(1, 1'b0, F3_W, 'h30, 32'h0, 1'b0, 32'h0, 1'b0, 3, "t5_dropped");
    idle(1);
    drain(1, "t5_st");
    check32("t5_in_wait", {31'h0, req_ready[1]}, 32'h0);
    #2 rst_n[1] = 1'b0;
    #4 rst_n[1] = 1'b1;
    #1;
    check32("t5_ready_after_rst", {31'h0, req_ready[1]}, 32'h1);
    repeat (5) @(posedge clk);
    #1;
    ld(1, F3_W, 'h30, 32'hCAFEF00D, 3, "t5_lw_kept");
    ld(1, F3_W, 'h20, 32'h11111111, 3, "t5_lw_old");
    idle(1);
    drain(1, "t5");

    // Big-endian byte order.
    st(2, F3_W, 'h0, 32'h11223344, "t6_sw");
    ld(2, F3_BU, 'h0, 32'h00000011, 1, "t6_lbu0");
    ld(2, F3_HU, 'h2, 32'h00003344, 1, "t6_lhu2");
    ld(2, F3_W, 'h0, 32'h11223344, 1, "t6_lw");
    ld(2, F3_B, 'h3, 32'h00000044, 1, "t6_lb3");
    ld(2, F3_H, 'h0, 32'h00001122, 1, "t6_lh0");
    st(2, F3_B, 'h1, 32'h00000080, "t6_sb1");
    ld(2, F3_W, 'h0, 32'h11803344, 1, "t6_lw_sb");
    ld(2, F3_B, 'h1, 32'hFFFFFF80, 1, "t6_lb1");
    st(2, F3_H, 'h2, 32'h0000A1B2, "t6_sh2");
    ld(2, F3_W, 'h0, 32'h1180A1B2, 1, "t6_lw_sh");
    idle(2);
    drain(2, "t6");

    repeat (3) @(posedge clk);
    #1;
    check32("final.pending", 32'(qsize(0) + qsize(1) + qsize(2)), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
